// File: rtl/accumulator_bank.sv
// Per-column partial-sum accumulator memory: NUM_COLS identical slices sharing addr/wr_en/acc_mode.
// Combinational read of the addressed word; each write overwrites or read-add-writes it.
module accumulator_bank #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_COLS   = 4,
    parameter int unsigned ACC_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic                          wr_en,
    input  logic                          acc_mode,
    input  logic [NUM_COLS*ACC_WIDTH-1:0] in_psum_vec,
    output logic [NUM_COLS*ACC_WIDTH-1:0] out_acc_vec
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        logic [ACC_WIDTH-1:0] r_mem [DEPTH];
        logic [DEPTH-1:0]     r_valid;
        logic [ACC_WIDTH-1:0] w_in;
        logic [ACC_WIDTH-1:0] w_cur;
        logic [ACC_WIDTH-1:0] w_next;

        assign w_in   = in_psum_vec[c*ACC_WIDTH +: ACC_WIDTH];
        assign w_cur  = r_valid[addr] ? r_mem[addr] : '0;
        assign w_next = acc_mode ? (w_cur + w_in) : w_in;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= '0;
            end else if (wr_en) begin
                r_valid[addr] <= 1'b1;
            end
        end

        // Data array is never reset; rst_n only gates writes so an edge during reset is discarded.
        always_ff @(posedge clk) begin
            if (rst_n && wr_en) begin
                r_mem[addr] <= w_next;
            end
        end

        assign out_acc_vec[c*ACC_WIDTH +: ACC_WIDTH] = w_cur;
    end

endmodule

// File: tb/tb_accumulator_bank.sv
// Self-checking bench for accumulator_bank: vector table, hand-written corner sequences,
// and randomized traffic against an associative-array reference model.
module tb_accumulator_bank;

    localparam int unsigned AW = 8;
    localparam int unsigned NC = 4;
    localparam int unsigned W  = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [AW-1:0]   addr = '0;
    logic            wr_en = 1'b0;
    logic            acc_mode = 1'b0;
    logic [NC*W-1:0] in_psum_vec = '0;
    logic [NC*W-1:0] out_acc_vec;

    int checks = 0;
    int errors = 0;

    // Reference: key = addr*NC + col; a missing key means "never written since reset".
    logic [W-1:0] model [int];

    accumulator_bank #(
        .ADDR_WIDTH(AW),
        .NUM_COLS  (NC),
        .ACC_WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .wr_en      (wr_en),
        .acc_mode   (acc_mode),
        .in_psum_vec(in_psum_vec),
        .out_acc_vec(out_acc_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic          mode;
        logic [AW-1:0] waddr;
        logic [W-1:0]  din;
        logic [AW-1:0] raddr;
        logic [W-1:0]  exp;
        string         name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic wr, input logic mode, input logic [AW-1:0] wa,
                                input logic [W-1:0] d, input logic [AW-1:0] ra,
                                input logic [W-1:0] e, input string n);
        vec_t v;
        v.wr = wr; v.mode = mode; v.waddr = wa; v.din = d;
        v.raddr = ra; v.exp = e; v.name = n;
        return v;
    endfunction

    function automatic logic [NC*W-1:0] bcast(input logic [W-1:0] x);
        logic [NC*W-1:0] v;
        for (int c = 0; c < NC; c++) v[c*W +: W] = x;
        return v;
    endfunction

    function automatic logic [W-1:0] mread(input logic [AW-1:0] a, input int c);
        int k;
        k = int'(a) * NC + c;
        return model.exists(k) ? model[k] : '0;
    endfunction

    function automatic logic [W-1:0] col(input int c);
        return out_acc_vec[c*W +: W];
    endfunction

    task automatic chk(input string nm, input int c, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s col%0d got %h expected %h at %0t", nm, c, act, exp, $time);
        end
    endtask

    task automatic model_write(input logic mode, input logic [AW-1:0] a, input logic [NC*W-1:0] v);
        for (int c = 0; c < NC; c++) begin
            logic [W-1:0] base;
            base = mode ? mread(a, c) : '0;
            model[int'(a) * NC + c] = base + v[c*W +: W];
        end
    endtask

    // One clock: drive at negedge, optionally check the pre-edge read, then let the edge happen.
    task automatic cycle(input logic we, input logic mode, input logic [AW-1:0] a,
                         input logic [NC*W-1:0] v, input bit pre_chk, input string nm);
        @(negedge clk);
        wr_en = we; acc_mode = mode; addr = a; in_psum_vec = v;
        if (pre_chk) begin
            #1;
            for (int c = 0; c < NC; c++) chk(nm, c, col(c), mread(a, c));
        end
        @(posedge clk);
        if (we && rst_n) model_write(mode, a, v);
    endtask

    task automatic rd_check(input logic [AW-1:0] a, input logic [W-1:0] exp, input string nm);
        @(negedge clk);
        wr_en = 1'b0; addr = a;
        #1;
        for (int c = 0; c < NC; c++) chk(nm, c, col(c), exp);
    endtask

    initial begin
        logic [NC*W-1:0] v;

        // Reset: output is 0 while in reset and after release with no writes.
        #1 rst_n = 1'b0;
        model.delete();
        #2;
        for (int c = 0; c < NC; c++) chk("in_reset_a0", c, col(c), '0);
        #9 rst_n = 1'b1;
        rd_check(8'd0,   '0, "t2_a0");
        rd_check(8'd5,   '0, "t2_a5");
        rd_check(8'd255, '0, "t2_a255");

        tbl.push_back(mk(1, 0, 8'd0,   32'd100, 8'd0,   32'd100, "t1_w0"));
        tbl.push_back(mk(1, 0, 8'd16,  32'd200, 8'd16,  32'd200, "t1_w16"));
        tbl.push_back(mk(1, 0, 8'd196, 32'd300, 8'd196, 32'd300, "t1_w196"));
        tbl.push_back(mk(0, 0, 8'd0,   32'd0,   8'd0,   32'd100, "t1_rd0"));
        tbl.push_back(mk(0, 1, 8'd16,  32'd7,   8'd16,  32'd200, "t1_rd16"));
        tbl.push_back(mk(0, 0, 8'd0,   32'd0,   8'd196, 32'd300, "t1_rd196"));
        tbl.push_back(mk(0, 0, 8'd0,   32'd0,   8'd255, 32'd0,   "t2_rd255"));
        tbl.push_back(mk(1, 1, 8'd7,   32'd42,  8'd7,   32'd42,  "t4_acc_new"));
        tbl.push_back(mk(1, 0, 8'd8,   32'hFFFF_FFFF, 8'd8, 32'hFFFF_FFFF, "t4_wmax"));
        tbl.push_back(mk(1, 1, 8'd8,   32'd2,   8'd8,   32'd1,   "t4_wrap"));
        tbl.push_back(mk(0, 0, 8'd0,   32'd0,   8'd9,   32'd0,   "t4_neighbour"));

        foreach (tbl[i]) begin
            if (tbl[i].wr) cycle(1'b1, tbl[i].mode, tbl[i].waddr, bcast(tbl[i].din), 1'b0, tbl[i].name);
            rd_check(tbl[i].raddr, tbl[i].exp, tbl[i].name);
        end

        // Back-to-back accumulates on consecutive edges; pre-edge read shows the old value.
        cycle(1'b1, 1'b0, 8'd3, bcast(32'd100), 1'b0, "t3_w");
        cycle(1'b1, 1'b1, 8'd3, bcast(32'd10), 1'b1, "t3_pre100");
        cycle(1'b1, 1'b1, 8'd3, bcast(32'hFFFF_FFEC), 1'b0, "t3_m20");
        @(negedge clk);
        wr_en = 1'b1; acc_mode = 1'b1; addr = 8'd3; in_psum_vec = bcast(32'd5);
        #1;
        for (int c = 0; c < NC; c++) chk("t3_pre90", c, col(c), 32'd90);
        @(posedge clk);
        model_write(1'b1, 8'd3, bcast(32'd5));
        rd_check(8'd3, 32'd95, "t3_sum");
        rd_check(8'd2, '0, "t3_nb2");
        rd_check(8'd4, '0, "t3_nb4");

        // Distinct per-column data, then a disabled write with changed inputs.
        for (int c = 0; c < NC; c++) v[c*W +: W] = W'(c + 1);
        cycle(1'b1, 1'b0, 8'd200, v, 1'b0, "t5_w");
        cycle(1'b0, 1'b1, 8'd200, bcast(32'd999), 1'b1, "t5_hold_pre");
        @(negedge clk);
        wr_en = 1'b0; addr = 8'd200;
        #1;
        for (int c = 0; c < NC; c++) chk("t5_col", c, col(c), W'(c + 1));
        rd_check(8'd196, 32'd300, "t5_other");

        // Asynchronous reset pulse between edges.
        @(negedge clk);
        wr_en = 1'b0; addr = 8'd196;
        #1;
        for (int c = 0; c < NC; c++) chk("t6_before", c, col(c), 32'd300);
        #1 rst_n = 1'b0;
        #1;
        for (int c = 0; c < NC; c++) chk("t6_during", c, col(c), '0);
        #1 rst_n = 1'b1;
        model.delete();
        #1;
        for (int c = 0; c < NC; c++) chk("t6_after", c, col(c), '0);
        rd_check(8'd196, '0, "t6_later");

        // Write on an edge while reset is asserted is discarded.
        @(negedge clk);
        wr_en = 1'b1; acc_mode = 1'b0; addr = 8'd50; in_psum_vec = bcast(32'd77);
        #3 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        model.delete();
        rd_check(8'd50, '0, "rst_discard");
        rd_check(8'd0, '0, "rst_clears_a0");

        // Randomized traffic on a small address window to force reuse and accumulation chains.
        for (int i = 0; i < 400; i++) begin
            logic [NC*W-1:0] rv;
            for (int c = 0; c < NC; c++) rv[c*W +: W] = $urandom;
            cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), rv, 1'b1, "rand_rd");
        end
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            wr_en = 1'b0; addr = AW'(a);
            #1;
            for (int c = 0; c < NC; c++) chk("rand_final", c, col(c), mread(AW'(a), c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
